// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 4-point radix-2 FFT core: loads 4 samples over valid/ready,
// waits a settle time, then drains the result words over valid/ready with backpressure.
module fft_frame_ctrl #(
    parameter int SETTLE_CYCLES  = 1,
    parameter int SKIP_ZERO_IMAG = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       core_wr_en,
    output logic [1:0] core_wr_idx,
    output logic [3:0] core_wr_data,
    output logic [2:0] core_rd_idx,
    input  logic [5:0] core_rd_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_data,
    output logic [1:0] out_bin,
    output logic       out_is_imag,
    output logic       out_first,
    output logic       out_last,
    output logic       frame_done,
    output logic [7:0] frame_count
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // Only meaningful when SETTLE_CYCLES > 0; the zero case bypasses SETTLE entirely.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_IDX    = 3'd7;

    state_t     state_reg, state_next;
    logic [1:0] load_cnt_reg, load_cnt_next;
    logic [3:0] settle_cnt_reg, settle_cnt_next;
    logic [2:0] rd_ptr_reg, rd_ptr_next;
    logic       frame_done_reg;
    logic [7:0] frame_count_reg;

    logic       accept;
    logic       frame_end;

    // Bin 0 and bin 2 of a real-input 4-point FFT have identically zero imaginary parts.
    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        logic [2:0] nxt;
        nxt = idx + 3'd1;
        if ((SKIP_ZERO_IMAG != 0) && ((nxt == 3'd1) || (nxt == 3'd5))) begin
            nxt = idx + 3'd2;
        end
        return nxt;
    endfunction

    always_comb begin
        state_next      = state_reg;
        load_cnt_next   = load_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        rd_ptr_next     = rd_ptr_reg;
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        accept          = 1'b0;
        frame_end       = 1'b0;

        case (state_reg)
            ST_LOAD: begin
                in_ready = 1'b1;
                accept   = in_valid & ~flush & ~reset;
                if (accept) begin
                    load_cnt_next = load_cnt_reg + 2'd1;
                    if (load_cnt_reg == 2'd3) begin
                        settle_cnt_next = 4'd0;
                        state_next      = (SETTLE_CYCLES == 0) ? ST_DRAIN : ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                settle_cnt_next = settle_cnt_reg + 4'd1;
                if (settle_cnt_reg == SETTLE_LAST) begin
                    settle_cnt_next = 4'd0;
                    state_next      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (rd_ptr_reg == LAST_IDX) begin
                        rd_ptr_next = 3'd0;
                        state_next  = ST_LOAD;
                        frame_end   = 1'b1;
                    end else begin
                        rd_ptr_next = next_idx(rd_ptr_reg);
                    end
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase

        // A word handshaking alongside flush is delivered, but the frame is not counted.
        if (flush) begin
            state_next      = ST_LOAD;
            load_cnt_next   = 2'd0;
            settle_cnt_next = 4'd0;
            rd_ptr_next     = 3'd0;
            frame_end       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_LOAD;
            load_cnt_reg    <= 2'd0;
            settle_cnt_reg  <= 4'd0;
            rd_ptr_reg      <= 3'd0;
            frame_done_reg  <= 1'b0;
            frame_count_reg <= 8'd0;
        end else begin
            state_reg      <= state_next;
            load_cnt_reg   <= load_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            rd_ptr_reg     <= rd_ptr_next;
            frame_done_reg <= frame_end;
            if (frame_end) begin
                frame_count_reg <= frame_count_reg + 8'd1;
            end
        end
    end

    assign core_wr_en   = accept;
    assign core_wr_idx  = load_cnt_reg;
    assign core_wr_data = in_data;
    assign core_rd_idx  = rd_ptr_reg;

    // The core is only written in LOAD, so out_data holds steady through a stall.
    assign out_data    = core_rd_data;
    assign out_bin     = rd_ptr_reg[2:1];
    assign out_is_imag = rd_ptr_reg[0];
    assign out_first   = out_valid & (rd_ptr_reg == 3'd0);
    assign out_last    = out_valid & (rd_ptr_reg == LAST_IDX);
    assign frame_done  = frame_done_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: three parameterisations, each with a behavioural FFT core attached,
// checked cycle by cycle against a DFT reference and the framing/latency rules.
module tb_fft_frame_ctrl;

    localparam int NDUT = 3;

    logic clk;
    logic       rst_s         [NDUT];
    logic       flush_s       [NDUT];
    logic       in_valid_s    [NDUT];
    logic       in_ready_s    [NDUT];
    logic [3:0] in_data_s     [NDUT];
    logic       core_wr_en_s  [NDUT];
    logic [1:0] core_wr_idx_s [NDUT];
    logic [3:0] core_wr_data_s[NDUT];
    logic [2:0] core_rd_idx_s [NDUT];
    logic       out_valid_s   [NDUT];
    logic       out_ready_s   [NDUT];
    logic [5:0] out_data_s    [NDUT];
    logic [1:0] out_bin_s     [NDUT];
    logic       out_is_imag_s [NDUT];
    logic       out_first_s   [NDUT];
    logic       out_last_s    [NDUT];
    logic       frame_done_s  [NDUT];
    logic [7:0] frame_count_s [NDUT];

    int checks = 0;
    int errors = 0;
    int exp_count [NDUT];
    logic [5:0] cap_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int settle_of(input int d);
        return (d == 1) ? 3 : ((d == 2) ? 0 : 1);
    endfunction

    function automatic int skip_of(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int SC = (gi == 1) ? 3 : ((gi == 2) ? 0 : 1);
        localparam int SZ = (gi == 1) ? 1 : 0;
        logic signed [5:0] mem [4];
        logic signed [5:0] a_sum, b_dif, c_sum, e_dif;
        logic [5:0] rd_data;

        fft_frame_ctrl #(.SETTLE_CYCLES(SC), .SKIP_ZERO_IMAG(SZ)) u_dut (
            .clk(clk), .reset(rst_s[gi]), .flush(flush_s[gi]),
            .in_valid(in_valid_s[gi]), .in_ready(in_ready_s[gi]), .in_data(in_data_s[gi]),
            .core_wr_en(core_wr_en_s[gi]), .core_wr_idx(core_wr_idx_s[gi]),
            .core_wr_data(core_wr_data_s[gi]), .core_rd_idx(core_rd_idx_s[gi]),
            .core_rd_data(rd_data), .out_valid(out_valid_s[gi]), .out_ready(out_ready_s[gi]),
            .out_data(out_data_s[gi]), .out_bin(out_bin_s[gi]), .out_is_imag(out_is_imag_s[gi]),
            .out_first(out_first_s[gi]), .out_last(out_last_s[gi]),
            .frame_done(frame_done_s[gi]), .frame_count(frame_count_s[gi])
        );

        // Butterfly-form core: sample registers plus result mux.
        always @(posedge clk) begin
            if (core_wr_en_s[gi]) begin
                mem[core_wr_idx_s[gi]] <= {{2{core_wr_data_s[gi][3]}}, core_wr_data_s[gi]};
            end
        end
        assign a_sum = mem[0] + mem[2];
        assign b_dif = mem[0] - mem[2];
        assign c_sum = mem[1] + mem[3];
        assign e_dif = mem[1] - mem[3];
        always_comb begin
            rd_data = 6'd0;
            case (core_rd_idx_s[gi])
                3'd0: rd_data = a_sum + c_sum;
                3'd2: rd_data = b_dif;
                3'd3: rd_data = -e_dif;
                3'd4: rd_data = a_sum - c_sum;
                3'd6: rd_data = b_dif;
                3'd7: rd_data = e_dif;
                default: rd_data = 6'd0;
            endcase
        end
    end

    // Direct DFT: X[k] = sum x[n] * (cos - j sin)(2*pi*n*k/4).
    function automatic logic [5:0] ref_word(input logic [15:0] smp, input int idx);
        int cs [4];
        int sn [4];
        int acc;
        int k;
        int x;
        int m;
        cs = '{1, 0, -1, 0};
        sn = '{0, 1, 0, -1};
        acc = 0;
        k = idx / 2;
        for (int n = 0; n < 4; n++) begin
            x = $signed(smp[n*4 +: 4]);
            m = (n * k) % 4;
            if (idx % 2 == 1) acc = acc - x * sn[m];
            else acc = acc + x * cs[m];
        end
        return acc[5:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int d);
        @(posedge clk); #1;
        rst_s[d] = 1'b1; flush_s[d] = 1'b0; in_valid_s[d] = 1'b1;
        in_data_s[d] = 4'($urandom); out_ready_s[d] = 1'b0;
        #1;
        check("rst_wr_masked", 32'(core_wr_en_s[d]), 32'd0);
        @(posedge clk); #1;
        rst_s[d] = 1'b0; in_valid_s[d] = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready_s[d]), 32'd1);
        check("rst_out_valid", 32'(out_valid_s[d]), 32'd0);
        check("rst_wr_en", 32'(core_wr_en_s[d]), 32'd0);
        check("rst_frame_done", 32'(frame_done_s[d]), 32'd0);
        check("rst_frame_count", 32'(frame_count_s[d]), 32'd0);
        exp_count[d] = 0;
        $display("reset dut%0d", d);
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1,0,0, 2 random. hold keeps in_valid high throughout.
    task automatic run_frames(input int d, input logic [15:0] smp, input int nframes,
                              input int rdy_mode, input bit hold);
        int idxq [$];
        logic [5:0] expw [$];
        logic [3:0] s [4];
        int loaded, words, frames, cyc, acc_cyc, done_cyc, limit, cur;
        bit exp_valid, exp_wr;
        for (int n = 0; n < 4; n++) s[n] = smp[n*4 +: 4];
        for (int i = 0; i < 8; i++) begin
            if (!(skip_of(d) != 0 && (i == 1 || i == 5))) begin
                idxq.push_back(i);
                expw.push_back(ref_word(smp, i));
            end
        end
        cap_q.delete();
        loaded = 0; words = 0; frames = 0; cyc = 0; acc_cyc = -100; done_cyc = -1;
        limit = 60 * nframes + 100;
        while (cyc < limit) begin
            @(posedge clk); #1;
            if (frames < nframes)
                in_valid_s[d] = hold ? 1'b1 : ((loaded < 4) && ($urandom_range(0, 3) != 0));
            else
                in_valid_s[d] = 1'b0;
            in_data_s[d] = (loaded < 4) ? s[loaded] : 4'($urandom);
            case (rdy_mode)
                0: out_ready_s[d] = 1'b1;
                1: out_ready_s[d] = (cyc % 3 == 0);
                default: out_ready_s[d] = 1'($urandom_range(0, 1));
            endcase
            #1;
            check("ready_valid_exclusive", 32'(in_ready_s[d] & out_valid_s[d]), 32'd0);
            check("frame_done", 32'(frame_done_s[d]), 32'(cyc == done_cyc));
            if (cyc == done_cyc) check("frame_count", 32'(frame_count_s[d]), 32'(exp_count[d]));
            check("in_ready", 32'(in_ready_s[d]), 32'(loaded < 4));
            exp_valid = (loaded == 4) && (cyc >= acc_cyc + settle_of(d) + 1);
            check("out_valid", 32'(out_valid_s[d]), 32'(exp_valid));
            exp_wr = in_valid_s[d] && (loaded < 4);
            check("core_wr_en", 32'(core_wr_en_s[d]), 32'(exp_wr));
            if (exp_wr && core_wr_en_s[d]) begin
                check("core_wr_idx", 32'(core_wr_idx_s[d]), 32'(loaded));
                check("core_wr_data", 32'(core_wr_data_s[d]), 32'(s[loaded]));
                loaded++;
                if (loaded == 4) acc_cyc = cyc;
            end
            if (exp_valid && out_valid_s[d]) begin
                cur = idxq[words];
                check("core_rd_idx", 32'(core_rd_idx_s[d]), 32'(cur));
                check("out_data", 32'(out_data_s[d]), 32'(expw[words]));
                check("out_bin", 32'(out_bin_s[d]), 32'(cur / 2));
                check("out_is_imag", 32'(out_is_imag_s[d]), 32'(cur % 2));
                check("out_first", 32'(out_first_s[d]), 32'(words == 0));
                check("out_last", 32'(out_last_s[d]), 32'(words == idxq.size() - 1));
                if (out_ready_s[d]) begin
                    cap_q.push_back(out_data_s[d]);
                    $display("dut%0d word idx=%0d data=0x%02h", d, cur, out_data_s[d]);
                    words++;
                    if (words == idxq.size()) begin
                        frames++;
                        exp_count[d] = (exp_count[d] + 1) % 256;
                        done_cyc = cyc + 1;
                        loaded = 0;
                        words = 0;
                    end
                end
            end
            if (frames == nframes && cyc == done_cyc) break;
            cyc++;
        end
        check("frames_completed", 32'(frames), 32'(nframes));
        in_valid_s[d] = 1'b0;
        out_ready_s[d] = 1'b0;
        $display("dut%0d frames=%0d samples=0x%04h count=%0d", d, frames, smp, frame_count_s[d]);
    endtask

    task automatic abort_drain(input int d, input bit use_reset);
        int loaded, words, cyc;
        loaded = 0; words = 0; cyc = 0;
        while (words < 4 && cyc < 100) begin
            @(posedge clk); #1;
            in_valid_s[d] = (loaded < 4);
            in_data_s[d] = 4'(loaded + 1);
            out_ready_s[d] = 1'b1;
            #1;
            if (in_valid_s[d] && in_ready_s[d]) loaded++;
            if (out_valid_s[d]) words++;
            cyc++;
        end
        check("abort_reach_word4", 32'(words), 32'd4);
        @(posedge clk); #1;
        in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b1;
        if (use_reset) rst_s[d] = 1'b1;
        else flush_s[d] = 1'b1;
        #1;
        check("abort_word_valid", 32'(out_valid_s[d]), 32'd1);
        check("abort_word_idx", 32'(core_rd_idx_s[d]), 32'd4);
        @(posedge clk); #1;
        rst_s[d] = 1'b0; flush_s[d] = 1'b0; out_ready_s[d] = 1'b0;
        #1;
        if (use_reset) exp_count[d] = 0;
        check("abort_out_valid", 32'(out_valid_s[d]), 32'd0);
        check("abort_in_ready", 32'(in_ready_s[d]), 32'd1);
        check("abort_frame_done", 32'(frame_done_s[d]), 32'd0);
        check("abort_frame_count", 32'(frame_count_s[d]), 32'(exp_count[d]));
        @(posedge clk); #1; #1;
        check("abort_no_done_later", 32'(frame_done_s[d]), 32'd0);
        $display("dut%0d abort in drain reset=%0d count=%0d", d, use_reset, frame_count_s[d]);
    endtask

    task automatic flush_mid_load(input int d);
        int loaded, cyc;
        loaded = 0; cyc = 0;
        while (loaded < 2 && cyc < 50) begin
            @(posedge clk); #1;
            in_valid_s[d] = 1'b1;
            in_data_s[d] = 4'($urandom);
            #1;
            if (in_ready_s[d]) begin
                check("flush_pre_idx", 32'(core_wr_idx_s[d]), 32'(loaded));
                loaded++;
            end
            cyc++;
        end
        @(posedge clk); #1;
        flush_s[d] = 1'b1; in_valid_s[d] = 1'b1; in_data_s[d] = 4'($urandom);
        #1;
        check("flush_blocks_write", 32'(core_wr_en_s[d]), 32'd0);
        @(posedge clk); #1;
        flush_s[d] = 1'b0; in_valid_s[d] = 1'b0;
        $display("dut%0d flushed after %0d samples", d, loaded);
    endtask

    logic [5:0] plan_full [8];
    logic [5:0] plan_skip [6];

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst_s[d] = 1'b1; flush_s[d] = 1'b0; in_valid_s[d] = 1'b0;
            in_data_s[d] = 4'd0; out_ready_s[d] = 1'b0; exp_count[d] = 0;
        end
        plan_full = '{6'h0A, 6'h00, 6'h3E, 6'h02, 6'h3E, 6'h00, 6'h3E, 6'h3E};
        plan_skip = '{6'h0A, 6'h3E, 6'h02, 6'h3E, 6'h3E, 6'h3E};

        for (int d = 0; d < NDUT; d++) do_reset(d);

        // Directed frame 1,2,3,4 with full readiness.
        run_frames(0, 16'h4321, 1, 0, 1'b0);
        for (int i = 0; i < 8; i++) check("plan_words", 32'(cap_q[i]), 32'(plan_full[i]));
        check("plan_count", 32'(frame_count_s[0]), 32'd1);

        // Same frame with a 1,0,0 ready pattern.
        run_frames(0, 16'h4321, 1, 1, 1'b0);
        for (int i = 0; i < 8; i++) check("stall_words", 32'(cap_q[i]), 32'(plan_full[i]));

        // Skipped-imaginary variant.
        run_frames(1, 16'h4321, 1, 0, 1'b0);
        check("skip_word_count", 32'(cap_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) check("skip_words", 32'(cap_q[i]), 32'(plan_skip[i]));

        // in_valid held through three back-to-back frames.
        do_reset(0);
        run_frames(0, 16'h7878, 3, 0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            check("hold_bin0_re", 32'(cap_q[f*8]), 32'h3E);
            check("hold_bin2_re", 32'(cap_q[f*8 + 4]), 32'h22);
        end
        check("hold_count", 32'(frame_count_s[0]), 32'd3);

        // Flush during load, then a clean frame.
        do_reset(0);
        flush_mid_load(0);
        run_frames(0, 16'(($urandom)), 1, 2, 1'b0);
        check("flush_count", 32'(frame_count_s[0]), 32'd1);

        // Abort during drain at word 4.
        abort_drain(0, 1'b1);
        run_frames(0, 16'h4321, 1, 0, 1'b0);
        abort_drain(0, 1'b0);

        // Randomised frames on every parameterisation.
        for (int d = 0; d < NDUT; d++) begin
            for (int f = 0; f < 4; f++) run_frames(d, 16'($urandom), 1, 2, 1'b0);
        end

        // Frame counter wrap through 255 -> 0.
        do_reset(2);
        run_frames(2, 16'($urandom), 257, 0, 1'b1);
        check("wrap_count", 32'(frame_count_s[2]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
